hex_readback_scanner: RTL and testbench

- Reader counterpart to the HEX display writer: snapshots the six DE-series 7-segment display registers on request and decodes each segment pattern back to a 4-bit hex digit.
- Flags blank and illegal patterns per display.
- Presents the digit chosen by SW[9:7] on LEDR so the user can check what each display holds.
- Sits beside the display writer at top level; its HEX inputs connect to the writer's HEX0..HEX5 outputs.

---
 rtl/hex_readback_scanner.sv | 207 ++++++++++++++++++++
 tb/tb_hex_readback_scanner.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_readback_scanner.sv
// ============================================================================
// Module   : hex_readback_scanner
// Brief    : Snapshots the six 7-segment display patterns on a KEY[1] press and
//            decodes each back to a hex digit with blank/illegal flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_readback_scanner #(
    parameter int NUM_DISP    = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLOCK_50,
    input  logic [3:0]            KEY,
    input  logic [9:0]            SW,
    input  logic [6:0]            HEX0,
    input  logic [6:0]            HEX1,
    input  logic [6:0]            HEX2,
    input  logic [6:0]            HEX3,
    input  logic [6:0]            HEX4,
    input  logic [6:0]            HEX5,
    output logic [4*NUM_DISP-1:0] Digits,
    output logic [NUM_DISP-1:0]   Valid,
    output logic [NUM_DISP-1:0]   Blank,
    output logic                  Busy,
    output logic                  Done,
    output logic [9:0]            LEDR
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CAPTURE = 2'd1;
    localparam logic [1:0] c_ST_SCAN    = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    localparam logic [2:0] c_LAST_IDX = 3'(NUM_DISP - 1);

    logic                   w_rst_n;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   r_prev;
    logic                   r_req;

    logic [1:0]             r_state;
    logic [2:0]             r_idx;
    logic                   r_busy;
    logic                   r_done;
    logic [6:0]             r_snap  [NUM_DISP];
    logic [3:0]             r_digit [NUM_DISP];
    logic [NUM_DISP-1:0]    r_valid;
    logic [NUM_DISP-1:0]    r_blank;
    logic [5:0]             w_dec;

    logic [2:0]             w_sel;
    logic [3:0]             w_led_digit;
    logic                   w_led_valid;
    logic                   w_led_blank;
    logic                   w_unused;

    assign w_rst_n  = KEY[0];
    assign w_unused = &{1'b0, KEY[3:2], SW[6:0]};

    // Returns {valid, blank, digit} for an active-low g..a segment pattern.
    function automatic logic [5:0] decode_glyph(input logic [6:0] seg);
        logic [5:0] res;
        res = 6'b00_0000;
        case (seg)
            7'b1000000: res = 6'b10_0000;
            7'b1111001: res = 6'b10_0001;
            7'b0100100: res = 6'b10_0010;
            7'b0110000: res = 6'b10_0011;
            7'b0011001: res = 6'b10_0100;
            7'b0010010: res = 6'b10_0101;
            7'b0000010: res = 6'b10_0110;
            7'b1111000: res = 6'b10_0111;
            7'b0000000: res = 6'b10_1000;
            7'b0010000: res = 6'b10_1001;
            7'b0001000: res = 6'b10_1010;
            7'b0000011: res = 6'b10_1011;
            7'b1000110: res = 6'b10_1100;
            7'b0100001: res = 6'b10_1101;
            7'b0000110: res = 6'b10_1110;
            7'b0001110: res = 6'b10_1111;
            7'b1111111: res = 6'b01_0000;
            default:    res = 6'b00_0000;
        endcase
        return res;
    endfunction

    // Synchronizer flops reset to 1 so that a release of reset is not a press.
    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
                if (!w_rst_n) r_sync <= '1;
                else          r_sync <= KEY[1];
            end
        end else begin : g_sync_chain
            always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
                if (!w_rst_n) r_sync <= '1;
                else          r_sync <= {r_sync[SYNC_STAGES-2:0], KEY[1]};
            end
        end
    endgenerate

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_prev <= 1'b1;
            r_req  <= 1'b0;
        end else begin
            r_prev <= w_sync;
            r_req  <= r_prev & ~w_sync;
        end
    end

    assign w_dec = decode_glyph(r_snap[r_idx]);

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= c_ST_IDLE;
            r_idx   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= '0;
            r_blank <= '0;
            for (int i = 0; i < NUM_DISP; i++) begin
                r_snap[i]  <= 7'd0;
                r_digit[i] <= 4'd0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_done <= 1'b0;
                    if (r_req) begin
                        r_state <= c_ST_CAPTURE;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_CAPTURE: begin
                    r_snap[0] <= HEX0;
                    r_snap[1] <= HEX1;
                    r_snap[2] <= HEX2;
                    r_snap[3] <= HEX3;
                    r_snap[4] <= HEX4;
                    r_snap[5] <= HEX5;
                    r_valid   <= '0;
                    r_blank   <= '0;
                    r_idx     <= 3'd0;
                    r_state   <= c_ST_SCAN;
                end
                c_ST_SCAN: begin
                    r_digit[r_idx] <= w_dec[3:0];
                    r_blank[r_idx] <= w_dec[4];
                    r_valid[r_idx] <= w_dec[5];
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= c_ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                c_ST_DONE: begin
                    r_done  <= 1'b0;
                    r_idx   <= 3'd0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_idx   <= 3'd0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DISP; gi++) begin : g_pack
            assign Digits[4*gi +: 4] = r_digit[gi];
        end
    endgenerate

    assign Valid = r_valid;
    assign Blank = r_blank;
    assign Busy  = r_busy;
    assign Done  = r_done;

    // Indices past the last display read as zero on the LEDs.
    assign w_sel = SW[9:7];

    always_comb begin
        w_led_digit = 4'd0;
        w_led_valid = 1'b0;
        w_led_blank = 1'b0;
        if (w_sel <= c_LAST_IDX) begin
            w_led_digit = r_digit[w_sel];
            w_led_valid = r_valid[w_sel];
            w_led_blank = r_blank[w_sel];
        end
    end

    assign LEDR = {r_busy, w_sel, w_led_blank, w_led_valid, w_led_digit};

endmodule

`default_nettype wire

// File: tb/tb_hex_readback_scanner.sv
// ============================================================================
// Module   : tb_hex_readback_scanner
// Brief    : Directed self-checking bench for hex_readback_scanner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_readback_scanner;

    localparam logic [6:0] c_P0  = 7'b1000000;
    localparam logic [6:0] c_P1  = 7'b1111001;
    localparam logic [6:0] c_P2  = 7'b0100100;
    localparam logic [6:0] c_P3  = 7'b0110000;
    localparam logic [6:0] c_P5  = 7'b0010010;
    localparam logic [6:0] c_P7  = 7'b1111000;
    localparam logic [6:0] c_PA  = 7'b0001000;
    localparam logic [6:0] c_PB  = 7'b0000011;
    localparam logic [6:0] c_PF  = 7'b0001110;
    localparam logic [6:0] c_BLK = 7'b1111111;
    localparam logic [6:0] c_ILL = 7'b0101010;

    logic        CLOCK_50;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [23:0] Digits;
    logic [5:0]  Valid, Blank;
    logic        Busy, Done;
    logic [9:0]  LEDR;

    int errors = 0;
    int checks = 0;

    hex_readback_scanner #(.NUM_DISP(6), .SYNC_STAGES(2)) dut (
        .CLOCK_50(CLOCK_50), .KEY(KEY), .SW(SW),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
        .Digits(Digits), .Valid(Valid), .Blank(Blank), .Busy(Busy), .Done(Done), .LEDR(LEDR)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic set_hex(input logic [6:0] h0, h1, h2, h3, h4, h5);
        HEX0 = h0; HEX1 = h1; HEX2 = h2; HEX3 = h3; HEX4 = h4; HEX5 = h5;
    endtask

    task automatic test_reset();
        int done_cnt, busy_cnt;
        KEY = 4'b1110;
        SW  = 10'b1010000000;
        set_hex(c_P0, c_P0, c_P0, c_P0, c_P0, c_P0);
        repeat (3) @(negedge CLOCK_50);
        checks++; if (Digits !== 24'h0) begin errors++; $display("FAIL reset_digits got=%h exp=%h", Digits, 24'h0); end
        checks++; if (Valid !== 6'h0 || Blank !== 6'h0) begin errors++; $display("FAIL reset_flags valid=%b blank=%b exp=0", Valid, Blank); end
        checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL reset_busy_done busy=%b done=%b exp=0", Busy, Done); end
        checks++; if (LEDR !== 10'b0101000000) begin errors++; $display("FAIL reset_ledr got=%b exp=%b", LEDR, 10'b0101000000); end
        KEY[0] = 1'b1;
        done_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLOCK_50);
            if (Done) done_cnt++;
            if (Busy) busy_cnt++;
        end
        checks++; if (done_cnt != 0 || busy_cnt != 0) begin errors++; $display("FAIL idle_quiet done=%0d busy=%0d exp=0", done_cnt, busy_cnt); end
        SW = 10'd0;
    endtask

    task automatic test_full_scan();
        int busy_cnt, first_busy, done_cnt, done_at;
        set_hex(c_P1, c_P2, c_P3, c_PA, c_PB, c_PF);
        @(negedge CLOCK_50);
        KEY[1] = 1'b0;
        busy_cnt = 0; first_busy = 0; done_cnt = 0; done_at = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLOCK_50);
            if (Busy) begin busy_cnt++; if (first_busy == 0) first_busy = k; end
            if (Done) begin done_cnt++; done_at = k; end
        end
        checks++; if (first_busy != 4) begin errors++; $display("FAIL busy_latency got=%0d exp=4", first_busy); end
        checks++; if (busy_cnt != 7) begin errors++; $display("FAIL busy_length got=%0d exp=7", busy_cnt); end
        checks++; if (done_cnt != 1 || done_at != 11) begin errors++; $display("FAIL done_timing cnt=%0d at=%0d exp cnt=1 at=11", done_cnt, done_at); end
        checks++; if (Digits !== 24'hFBA321) begin errors++; $display("FAIL full_digits got=%h exp=%h", Digits, 24'hFBA321); end
        checks++; if (Valid !== 6'b111111 || Blank !== 6'b000000) begin errors++; $display("FAIL full_flags valid=%b blank=%b exp 111111/000000", Valid, Blank); end
        KEY[1] = 1'b1;
        repeat (4) @(negedge CLOCK_50);
    endtask

    task automatic test_blank_illegal();
        bit seen;
        set_hex(c_P0, c_P0, c_BLK, c_P0, c_ILL, c_P0);
        @(negedge CLOCK_50);
        KEY[1] = 1'b0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge CLOCK_50);
            if (Done) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL blank_done_timeout got=0 exp=1"); end
        checks++; if (Valid !== 6'b101011) begin errors++; $display("FAIL blank_valid got=%b exp=%b", Valid, 6'b101011); end
        checks++; if (Blank !== 6'b000100) begin errors++; $display("FAIL blank_blank got=%b exp=%b", Blank, 6'b000100); end
        checks++; if (Digits !== 24'h000000) begin errors++; $display("FAIL blank_digits got=%h exp=%h", Digits, 24'h0); end
        SW[9:7] = 3'd2;
        #1;
        checks++; if (LEDR !== 10'b0010100000) begin errors++; $display("FAIL ledr_blank got=%b exp=%b", LEDR, 10'b0010100000); end
        SW[9:7] = 3'd4;
        #1;
        checks++; if (LEDR !== 10'b0100000000) begin errors++; $display("FAIL ledr_illegal got=%b exp=%b", LEDR, 10'b0100000000); end
        SW = 10'd0;
        KEY[1] = 1'b1;
        repeat (4) @(negedge CLOCK_50);
    endtask

    task automatic test_snapshot_held();
        int busy_k, done_cnt;
        bit seen;
        set_hex(c_P5, c_P0, c_P0, c_P0, c_P0, c_P0);
        @(negedge CLOCK_50);
        KEY[1] = 1'b0;
        busy_k = 0;
        for (int k = 1; k <= 20 && busy_k == 0; k++) begin
            @(negedge CLOCK_50);
            if (Busy) busy_k = k;
        end
        checks++; if (busy_k != 4) begin errors++; $display("FAIL snap_busy_rise got=%0d exp=4", busy_k); end
        repeat (2) @(negedge CLOCK_50);
        HEX0 = c_P7;
        done_cnt = 0;
        for (int k = 0; k < 44; k++) begin
            @(negedge CLOCK_50);
            if (Done) done_cnt++;
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL held_key_done got=%0d exp=1", done_cnt); end
        checks++; if (Digits[3:0] !== 4'h5) begin errors++; $display("FAIL snap_isolation got=%h exp=5", Digits[3:0]); end
        KEY[1] = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        KEY[1] = 1'b0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge CLOCK_50);
            if (Done) seen = 1;
        end
        checks++; if (!seen || Digits[3:0] !== 4'h7) begin errors++; $display("FAIL second_press seen=%0d got=%h exp=7", seen, Digits[3:0]); end
        KEY[1] = 1'b1;
        repeat (4) @(negedge CLOCK_50);
    endtask

    task automatic test_busy_drop_ledr();
        int busy_cnt, done_cnt;
        set_hex(c_P1, c_P2, c_P3, c_PA, c_PB, c_PF);
        @(negedge CLOCK_50);
        KEY[1] = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge CLOCK_50);
            if (Busy) busy_cnt++;
            if (Done) done_cnt++;
            if (k == 4) KEY[1] = 1'b1;
            if (k == 6) KEY[1] = 1'b0;
            if (k == 8) KEY[1] = 1'b1;
        end
        checks++; if (done_cnt != 1 || busy_cnt != 7) begin errors++; $display("FAIL req_dropped done=%0d busy=%0d exp 1/7", done_cnt, busy_cnt); end
        SW[9:7] = 3'd3;
        #1;
        checks++; if (LEDR[4:0] !== 5'b11010) begin errors++; $display("FAIL ledr_sel3 got=%b exp=%b", LEDR[4:0], 5'b11010); end
        checks++; if (LEDR !== 10'b0011011010) begin errors++; $display("FAIL ledr_sel3_full got=%b exp=%b", LEDR, 10'b0011011010); end
        SW[9:7] = 3'd7;
        #1;
        checks++; if (LEDR !== 10'b0111000000) begin errors++; $display("FAIL ledr_sel7 got=%b exp=%b", LEDR, 10'b0111000000); end
        SW[9:7] = 3'd6;
        #1;
        checks++; if (LEDR !== 10'b0110000000) begin errors++; $display("FAIL ledr_sel6 got=%b exp=%b", LEDR, 10'b0110000000); end
        SW = 10'd0;
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic test_reset_mid_scan();
        int done_cnt;
        bit seen;
        set_hex(c_P1, c_P2, c_P3, c_PA, c_PB, c_PF);
        @(negedge CLOCK_50);
        KEY[1] = 1'b0;
        repeat (7) @(negedge CLOCK_50);
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL midscan_busy got=%b exp=1", Busy); end
        KEY = 4'b1110;
        #1;
        checks++; if (Digits !== 24'h0 || Valid !== 6'h0 || Blank !== 6'h0) begin errors++; $display("FAIL async_clear digits=%h valid=%b blank=%b exp=0", Digits, Valid, Blank); end
        checks++; if (Busy !== 1'b0 || LEDR[9] !== 1'b0) begin errors++; $display("FAIL async_busy busy=%b ledr9=%b exp=0", Busy, LEDR[9]); end
        done_cnt = 0;
        repeat (2) begin @(negedge CLOCK_50); if (Done) done_cnt++; end
        KEY[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLOCK_50);
            if (Done) done_cnt++;
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL no_done_after_reset got=%0d exp=0", done_cnt); end
        KEY[1] = 1'b0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge CLOCK_50);
            if (Done) seen = 1;
        end
        checks++; if (!seen || Digits !== 24'hFBA321 || Valid !== 6'b111111) begin errors++; $display("FAIL fresh_scan seen=%0d digits=%h valid=%b exp FBA321/111111", seen, Digits, Valid); end
        KEY[1] = 1'b1;
        repeat (3) @(negedge CLOCK_50);
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_blank_illegal();
        test_snapshot_held();
        test_busy_drop_ledr();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
